op_decoder_pipe: RTL and testbench

//   Registered, parametrised one-hot decoder that selects the active ALU

---
 rtl/op_decoder_pipe.sv | 81 ++++++++
 tb/tb_op_decoder_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/op_decoder_pipe.sv
`default_nettype none
// ============================================================================
// op_decoder_pipe : registered one-hot opcode decoder, valid/ready handshake
// Rev 1.0
// ============================================================================
module op_decoder_pipe #(
  parameter int                      SEL_W      = 3,
  parameter logic [(2**SEL_W)-1:0]   LEGAL_MASK = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    enable,
  input  logic [SEL_W-1:0]        select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**SEL_W)-1:0]   out,
  output logic                    illegal,
  output logic                    err_sticky,
  input  logic                    err_clr
);

  localparam int c_num_ops = 2**SEL_W;

  logic [c_num_ops-1:0] w_onehot;
  logic                 w_legal;
  logic                 w_dec_ill;
  logic                 w_accept;
  logic                 w_xfer;

  logic                 r_valid;
  logic [c_num_ops-1:0] r_out;
  logic                 r_illegal;
  logic                 r_err;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_valid && out_ready;
  assign w_legal   = LEGAL_MASK[select];
  assign w_dec_ill = enable && !w_legal;

  // Illegal opcodes gate every line, so the bus is zero or one-hot by construction.
  generate
    for (genvar gi = 0; gi < c_num_ops; gi++) begin : g_dec
      assign w_onehot[gi] = enable && w_legal && (select == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_out     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_out     <= w_onehot;
      r_illegal <= w_dec_ill;
    end else if (w_xfer) begin
      r_valid   <= 1'b0;
    end
  end

  // An illegal accept takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && w_dec_ill) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out        = r_out;
  assign illegal    = r_illegal;
  assign err_sticky = r_err;

endmodule
`default_nettype wire

// File: tb/tb_op_decoder_pipe.sv
`default_nettype none
// Scoreboard bench for op_decoder_pipe across SEL_W = 3 (two masks), 1, 2 and 4.
module tb_op_decoder_pipe;

  localparam int NDUT = 5;
  localparam int          SW [NDUT] = '{3, 3, 1, 2, 4};
  localparam logic [15:0] MK [NDUT] = '{16'h00FF, 16'h007F, 16'h0001, 16'h000B, 16'hEFFF};

  typedef struct packed {
    logic [15:0] o;
    logic        ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] select = 4'd0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       done = 1'b0;

  logic [15:0] d_out [NDUT];
  logic        d_ov  [NDUT];
  logic        d_ill [NDUT];
  logic        d_err [NDUT];
  logic        d_rdy [NDUT];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = SW[g];
      logic [(2**W)-1:0] w_o;
      assign d_out[g] = 16'(w_o);
      op_decoder_pipe #(
        .SEL_W      (W),
        .LEGAL_MASK (MK[g][(2**W)-1:0])
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (d_rdy[g]),
        .enable     (enable),
        .select     (select[W-1:0]),
        .out_valid  (d_ov[g]),
        .out_ready  (out_ready),
        .out        (w_o),
        .illegal    (d_ill[g]),
        .err_sticky (d_err[g]),
        .err_clr    (err_clr)
      );
    end
  endgenerate

  // ---------------------------------------------------------------- model
  function automatic exp_t decode(input int w, input logic [15:0] mk,
                                  input logic en, input logic [3:0] sel);
    exp_t e;
    int   s;
    s = int'(sel) & ((1 << w) - 1);
    e.o   = 16'h0;
    e.ill = 1'b0;
    if (en) begin
      if (mk[s]) e.o = 16'h1 << s;
      else       e.ill = 1'b1;
    end
    return e;
  endfunction

  exp_t        sb_q [NDUT][$];
  logic        m_ov  [NDUT];
  logic [15:0] m_out [NDUT];
  logic        m_ill [NDUT];
  logic        m_err [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d (SEL_W=%0d) t=%0t: got %h expected %h", nm, k, SW[k], $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------- monitor
  initial begin : monitor
    exp_t e;
    logic acc, xfer, exp_rdy;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rst) begin
          chk("rst_out_valid", k, 16'(d_ov[k]), 16'h0);
          chk("rst_out", k, d_out[k], 16'h0);
          chk("rst_illegal", k, 16'(d_ill[k]), 16'h0);
          chk("rst_err_sticky", k, 16'(d_err[k]), 16'h0);
          sb_q[k].delete();
          m_ov[k]  = 1'b0;
          m_out[k] = 16'h0;
          m_ill[k] = 1'b0;
          m_err[k] = 1'b0;
        end else begin
          chk("out_valid", k, 16'(d_ov[k]), 16'(m_ov[k]));
          chk("out", k, d_out[k], m_out[k]);
          chk("illegal", k, 16'(d_ill[k]), 16'(m_ill[k]));
          chk("err_sticky", k, 16'(d_err[k]), 16'(m_err[k]));
          chk("onehot", k, 16'($countones(d_out[k]) <= 1), 16'h1);
          chk("ill_zero_out", k, 16'(d_ill[k] && (d_out[k] != 16'h0)), 16'h0);
          exp_rdy = !m_ov[k] || out_ready;
          chk("in_ready", k, 16'(d_rdy[k]), 16'(exp_rdy));

          if (d_ov[k] && out_ready) begin
            if (sb_q[k].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL sb_unexpected dut%0d t=%0t: got out=%h with no expected entry", k, $time, d_out[k]);
            end else begin
              e = sb_q[k].pop_front();
              chk("sb_out", k, d_out[k], e.o);
              chk("sb_illegal", k, 16'(d_ill[k]), 16'(e.ill));
            end
          end

          // Advance the model to the state after the coming rising edge.
          acc  = in_valid && exp_rdy;
          xfer = m_ov[k] && out_ready;
          if (acc) begin
            e = decode(SW[k], MK[k], enable, select);
            sb_q[k].push_back(e);
            m_ov[k]  = 1'b1;
            m_out[k] = e.o;
            m_ill[k] = e.ill;
          end else if (xfer) begin
            m_ov[k] = 1'b0;
          end
          if (acc && e.ill) m_err[k] = 1'b1;
          else if (err_clr) m_err[k] = 1'b0;
        end
      end
      if (done) break;
    end
    for (int k = 0; k < NDUT; k++)
      chk("sb_drained", k, 16'(sb_q[k].size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------- stimulus
  task automatic drive(input logic v, input logic en, input logic [3:0] sel,
                       input logic ordy, input logic clr);
    in_valid  = v;
    enable    = en;
    select    = sel;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single decode of opcode 5
    drive(1, 1, 4'd5, 1, 0);
    drive(0, 0, 4'd0, 1, 0);

    // Back-to-back stream of every 3-bit opcode
    for (int s = 0; s < 8; s++) drive(1, 1, 4'(s), 1, 0);
    drive(0, 0, 4'd0, 1, 0);

    // Backpressure: result held, second opcode waits
    drive(1, 1, 4'd2, 0, 0);
    repeat (5) drive(1, 1, 4'd6, 0, 0);
    drive(1, 1, 4'd6, 1, 0);
    drive(0, 0, 4'd0, 1, 0);

    // Illegal opcode, clear alone, clear colliding with illegal accept
    drive(1, 1, 4'd7, 1, 0);
    drive(0, 0, 4'd0, 1, 1);
    drive(0, 0, 4'd0, 1, 0);
    drive(1, 1, 4'd7, 1, 0);
    drive(1, 1, 4'd7, 1, 1);
    drive(0, 0, 4'd0, 1, 0);

    // Bubble
    drive(1, 0, 4'd3, 1, 0);
    drive(0, 0, 4'd0, 1, 0);

    // Reset while a result is held under backpressure
    drive(1, 1, 4'd4, 0, 0);
    drive(1, 1, 4'd4, 0, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1, 4'd1, 1, 0);

    // Mixed sweep across all selects, bubbles, stalls and clears
    for (int i = 0; i < 48; i++)
      drive((i % 7) != 3, (i % 5) != 0, 4'(i * 7), (i % 3) != 2, (i == 20) || (i == 33));

    repeat (3) drive(0, 0, 4'd0, 1, 0);
    done = 1'b1;
  end

endmodule
`default_nettype wire
